// File: rtl/data_memory_pipelined_if.sv
// Request/response bus for data_memory_pipelined.
// master: the MEM-stage requester; slave: the memory.
interface data_memory_pipelined_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_memory_pipelined.sv
// Pipelined little-endian data memory for the MEM stage.
// Byte/half/word loads and stores, sign/zero-extended loads, error reporting for
// misaligned, reserved-size and out-of-range accesses, fixed RD_LATENCY response.
// Optional feature macro: MEM_CLEAR_ON_RESET_EN -- zero-fill sweep after reset,
// req_ready held low while sweeping.
module data_memory_pipelined #(
    parameter int unsigned BIT_NUMBER     = 8,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned DEPTH_WORDS    = 1024,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned RD_LATENCY     = 1   // legal range 1..4
) (
    input logic clk,
    input logic rst,
    data_memory_pipelined_if.slave bus
);
    localparam int unsigned W          = BIT_NUMBER * BYTES_PER_WORD;
    localparam int unsigned LANE_W     = $clog2(BYTES_PER_WORD);
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam int unsigned NB_W       = LANE_W + 1;
    localparam int unsigned AW1        = ADDR_W + 1;
    localparam int unsigned BYTE_SPACE = DEPTH_WORDS * BYTES_PER_WORD;

    logic [W-1:0] mem [DEPTH_WORDS];

    logic [LANE_W-1:0]         lane;
    logic [IDX_W-1:0]          word_idx;
    logic [NB_W-1:0]           nbytes;
    logic [AW1-1:0]            end_addr;
    logic                      err;
    logic                      accept;
    logic                      store_en;
    logic [BYTES_PER_WORD-1:0] be;
    logic [W-1:0]              wdata_sh;
    logic [W-1:0]              rd_word;
    logic [W-1:0]              rword_sh;
    logic [W-1:0]              load_data;

    logic                      wr_en;
    logic [IDX_W-1:0]          wr_idx;
    logic [BYTES_PER_WORD-1:0] wr_be;
    logic [W-1:0]              wr_data;

    logic         valid_q [RD_LATENCY];
    logic [W-1:0] data_q  [RD_LATENCY];
    logic         err_q   [RD_LATENCY];

    assign lane     = bus.req_addr[LANE_W-1:0];
    assign word_idx = bus.req_addr[LANE_W +: IDX_W];
    assign rd_word  = mem[word_idx];
    assign accept   = bus.req_valid & bus.req_ready & ~rst;
    assign store_en = accept & bus.req_we & ~err;

    // Decode access width and flag misalignment, reserved size and range errors.
    always_comb begin
        nbytes = '0;
        err    = 1'b0;
        case (bus.req_size)
            2'b00: nbytes = NB_W'(1);
            2'b01: begin
                nbytes = NB_W'(2);
                if (lane[0]) err = 1'b1;
            end
            2'b10: begin
                nbytes = NB_W'(BYTES_PER_WORD);
                if (lane != '0) err = 1'b1;
            end
            default: err = 1'b1;
        endcase
        // Widened by one bit so addresses near the top of ADDR_W cannot wrap into range.
        end_addr = {1'b0, bus.req_addr} + AW1'(nbytes);
        if (end_addr > AW1'(BYTE_SPACE)) err = 1'b1;
    end

    // Lane alignment: shift store data up to the addressed lane, read word down to lane 0.
    always_comb begin
        be       = '0;
        wdata_sh = '0;
        rword_sh = '0;
        for (int i = 0; i < int'(BYTES_PER_WORD); i++) begin
            if (int'(lane) == i) begin
                wdata_sh = bus.req_wdata << (i * int'(BIT_NUMBER));
                rword_sh = rd_word >> (i * int'(BIT_NUMBER));
            end
            be[i] = (i >= int'(lane)) && (i < int'(lane) + int'(nbytes));
        end
    end

    // Extend the right-aligned load data; word loads ignore req_signed.
    always_comb begin
        load_data = '0;
        case (bus.req_size)
            2'b00: load_data = {{(W - BIT_NUMBER){bus.req_signed & rword_sh[BIT_NUMBER-1]}},
                                rword_sh[BIT_NUMBER-1:0]};
            2'b01: load_data = {{(W - 2 * BIT_NUMBER){bus.req_signed &
                                                      rword_sh[2*BIT_NUMBER-1]}},
                                rword_sh[2*BIT_NUMBER-1:0]};
            2'b10: load_data = rword_sh;
            default: load_data = '0;
        endcase
    end

`ifdef MEM_CLEAR_ON_RESET_EN
    logic             sweep_q;
    logic [IDX_W-1:0] sweep_idx_q;

    // Zero-fill sweep: restarts at word 0 on every reset cycle, one word per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_q     <= 1'b1;
            sweep_idx_q <= '0;
        end else if (sweep_q) begin
            sweep_idx_q <= sweep_idx_q + IDX_W'(1);
            if (sweep_idx_q == IDX_W'(DEPTH_WORDS - 1)) sweep_q <= 1'b0;
        end
    end

    assign bus.req_ready = ~sweep_q;
`else
    assign bus.req_ready = 1'b1;
`endif

    // Merge the store port and (optionally) the clear sweep into one write port.
    always_comb begin
        wr_en   = store_en;
        wr_idx  = word_idx;
        wr_be   = be;
        wr_data = wdata_sh;
`ifdef MEM_CLEAR_ON_RESET_EN
        // No store can coincide with the sweep because req_ready is low.
        if (sweep_q && !rst) begin
            wr_en   = 1'b1;
            wr_idx  = sweep_idx_q;
            wr_be   = '1;
            wr_data = '0;
        end
`endif
    end

    // Byte-lane masked write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < int'(BYTES_PER_WORD); i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][i*BIT_NUMBER +: BIT_NUMBER] <= wr_data[i*BIT_NUMBER +: BIT_NUMBER];
                end
            end
        end
    end

    // Fixed-latency response shift register; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
                err_q[i]   <= 1'b0;
            end
        end else begin
            valid_q[0] <= accept;
            data_q[0]  <= (accept && !bus.req_we && !err) ? load_data : '0;
            err_q[0]   <= accept & err;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
                err_q[i]   <= err_q[i-1];
            end
        end
    end

    assign bus.rsp_valid = valid_q[RD_LATENCY-1];
    assign bus.rsp_rdata = data_q[RD_LATENCY-1];
    assign bus.rsp_err   = err_q[RD_LATENCY-1];
endmodule

// File: tb/tb_data_memory_pipelined.sv
// Bench for data_memory_pipelined: directed vector table, randomized traffic against
// a byte-array reference model, latency/ordering scoreboard and reset/sweep sequences.
module tb_data_memory_pipelined;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned LAT    = 3;
    localparam int unsigned BSPACE = DEPTH * 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_memory_pipelined_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    data_memory_pipelined #(
        .BIT_NUMBER    (8),
        .BYTES_PER_WORD(4),
        .DEPTH_WORDS   (DEPTH),
        .ADDR_W        (32),
        .RD_LATENCY    (LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int unsigned due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    logic [7:0]  ref_mem [BSPACE];
    exp_t        exp_q[$];
    vec_t        vecs[$];
    int unsigned cycle = 0;
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    // Reference model: byte array, little-endian, arithmetic sign extension.
    function automatic void model_access(input logic we, input logic [1:0] size,
                                         input logic sgn, input logic [31:0] addr,
                                         input logic [31:0] wdata,
                                         output logic [31:0] rdata, output logic err);
        int unsigned       n;
        longint unsigned   a64;
        longint unsigned   val;
        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        a64 = {32'd0, addr};
        err = (size == 2'd3) || (a64 % n != 0) || (a64 + n > BSPACE);
        rdata = 32'd0;
        if (!err) begin
            if (we) begin
                for (int k = 0; k < int'(n); k++) ref_mem[a64 + k] = wdata[8*k +: 8];
            end else begin
                val = 0;
                for (int k = 0; k < int'(n); k++) val = val | ({56'd0, ref_mem[a64 + k]} << (8 * k));
                if (sgn && n < 4 && val[8*n-1]) val = val - (64'd1 << (8 * n));
                rdata = val[31:0];
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Called #1 after a posedge; returns #1 after the accepting posedge.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic use_tab, input logic [31:0] t_rdata, input logic t_err);
        exp_t        e;
        logic [31:0] m_rdata;
        logic        m_err;
        int          waited;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        waited = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (bus.req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout: ready=%b after %0d cycles, required 1", bus.req_ready, waited);
            bus.req_valid = 1'b0;
            return;
        end
        model_access(we, size, sgn, addr, wdata, m_rdata, m_err);
        e.due   = cycle + LAT;
        e.rdata = use_tab ? t_rdata : m_rdata;
        e.err   = use_tab ? t_err : m_err;
        exp_q.push_back(e);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    // Reset for one clock edge; in-flight responses are dropped.
    task automatic pulse_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        exp_q.delete();
`ifdef MEM_CLEAR_ON_RESET_EN
        for (int i = 0; i < int'(BSPACE); i++) ref_mem[i] = 8'd0;
`endif
        #1 rst = 1'b0;
    endtask

    task automatic measure_low(output int lows);
        lows = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && lows < 200) begin
            lows++;
            @(negedge clk);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic err);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr;
        v.wdata = wdata; v.rdata = rdata; v.err = err;
        return v;
    endfunction

    // Scoreboard: each expected response must appear exactly at its due cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].due == cycle) begin
                checks++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp_q[0].rdata ||
                    bus.rsp_err !== exp_q[0].err) begin
                    errors++;
                    $display("FAIL rsp@%0d: valid=%b rdata=%h err=%b, required valid=1 rdata=%h err=%b",
                             cycle, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err,
                             exp_q[0].rdata, exp_q[0].err);
                end
                void'(exp_q.pop_front());
            end else begin
                checks++;
                if (bus.rsp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL unexpected_rsp@%0d: valid=%b, required 0", cycle, bus.rsp_valid);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lows;
        int unsigned r;
        int unsigned n;
        logic [31:0] addr;
        logic [1:0]  size;

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        for (int i = 0; i < int'(BSPACE); i++) ref_mem[i] = 8'd0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("reset_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
`ifdef MEM_CLEAR_ON_RESET_EN
        measure_low(lows);
        check("sweep_low_cycles", lows, DEPTH);
        @(posedge clk); #1;
        for (int w = 0; w < int'(DEPTH); w++) do_req(1'b0, 2'd2, 1'b0, w * 4, 32'd0, 1'b1, 32'd0, 1'b0);
`else
        @(negedge clk);
        check("ready_after_reset", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
`endif

        // Prefill so every byte is known to the model.
        for (int w = 0; w < int'(DEPTH); w++) do_req(1'b1, 2'd2, 1'b0, w * 4, $urandom, 1'b0, 32'd0, 1'b0);

        // Directed vectors
        vecs.push_back(mk(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0));
        vecs.push_back(mk(0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 2'd0, 1, 32'h13, 32'h0, 32'hFFFFFFDE, 0));
        vecs.push_back(mk(0, 2'd0, 0, 32'h13, 32'h0, 32'h000000DE, 0));
        vecs.push_back(mk(0, 2'd1, 1, 32'h10, 32'h0, 32'hFFFFBEEF, 0));
        vecs.push_back(mk(0, 2'd1, 0, 32'h12, 32'h0, 32'h0000DEAD, 0));
        vecs.push_back(mk(1, 2'd0, 0, 32'h11, 32'hAAAAAA55, 32'h0, 0));
        vecs.push_back(mk(0, 2'd2, 0, 32'h10, 32'h0, 32'hDEAD55EF, 0));
        vecs.push_back(mk(0, 2'd1, 0, 32'h11, 32'h0, 32'h0, 1));
        vecs.push_back(mk(1, 2'd2, 0, 32'h12, 32'h12345678, 32'h0, 1));
        vecs.push_back(mk(0, 2'd0, 0, BSPACE, 32'h0, 32'h0, 1));
        vecs.push_back(mk(1, 2'd2, 0, BSPACE, 32'h11111111, 32'h0, 1));
        vecs.push_back(mk(0, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 2'd2, 0, 32'h80000010, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 2'd2, 1, 32'h10, 32'h0, 32'hDEAD55EF, 0));
        vecs.push_back(mk(1, 2'd1, 0, 32'h3E, 32'h0000CAFE, 32'h0, 0));
        vecs.push_back(mk(0, 2'd1, 0, 32'h3E, 32'h0, 32'h0000CAFE, 0));
        vecs.push_back(mk(0, 2'd0, 1, 32'h3F, 32'h0, 32'hFFFFFFCA, 0));
        vecs.push_back(mk(1, 2'd2, 0, 32'h3C, 32'h80007F01, 32'h0, 0));
        vecs.push_back(mk(0, 2'd1, 1, 32'h3E, 32'h0, 32'hFFFF8000, 0));
        vecs.push_back(mk(0, 2'd0, 1, 32'h3D, 32'h0, 32'h0000007F, 0));
        vecs.push_back(mk(0, 2'd0, 0, 32'h3C, 32'h0, 32'h00000001, 0));
        vecs.push_back(mk(0, 2'd2, 0, 32'h3D, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 2'd1, 0, 32'h3F, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 2'd2, 0, 32'hFFFFFFFC, 32'h0, 32'h0, 1));
        for (int i = 0; i < vecs.size(); i++) begin
            do_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                   1'b1, vecs[i].rdata, vecs[i].err);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            r    = $urandom_range(0, 9);
            size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
            if (r < 7)      addr = $urandom_range(0, BSPACE - 1);
            else if (r < 9) addr = $urandom_range(BSPACE - 4, BSPACE + 8);
            else            addr = {1'b1, 31'($urandom)};
            if ($urandom_range(0, 3) != 0) addr = addr & ~(n - 1);
            do_req(1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr, $urandom,
                   1'b0, 32'd0, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        // Back-to-back loads: consecutive pulses, in order
        do_req(1'b0, 2'd2, 1'b0, 32'h00, 32'd0, 1'b0, 32'd0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h04, 32'd0, 1'b0, 32'd0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'd0, 1'b0, 32'd0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0, 32'd0, 1'b0);

        // Reset after the 2nd of a burst drops both responses
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0, 32'd0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'd0, 1'b0, 32'd0, 1'b0);
        pulse_reset();
        for (int i = 0; i < int'(LAT) + 2; i++) begin
            @(negedge clk);
            check("no_rsp_after_reset", {31'd0, bus.rsp_valid}, 32'd0);
        end
`ifdef MEM_CLEAR_ON_RESET_EN
        @(posedge clk); #1;
        measure_low(lows);

        // Mid-sweep reset restarts the full sweep
        pulse_reset();
        repeat (8) @(negedge clk);
        check("ready_mid_sweep", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clk); #1;
        pulse_reset();
        measure_low(lows);
        check("sweep_restart_low_cycles", lows, DEPTH);
`endif
        @(posedge clk); #1;
        // Memory contents after reset match the model (unchanged or zeroed)
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0, 32'd0, 1'b0);
        do_req(1'b0, 2'd0, 1'b1, 32'h3C, 32'd0, 1'b0, 32'd0, 1'b0);

        repeat (LAT + 2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
